// File: rtl/adc_spi_reader.sv
// Polls a 12-bit SPI ADC (16-bit frame, 4 leading zeros, MSB first) and publishes accepted results.
// Define ADC_AVG_EN to publish the truncated mean of every four accepted frames instead of each one.
module adc_spi_reader #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned SAMPLE_GAP = 64
) (
   input  logic        clk,
   input  logic        rst,
   output logic        adc_cs_n,
   output logic        adc_sclk,
   input  logic        adc_miso,
   output logic [11:0] adc_value,
   output logic        adc_value_change,
   output logic        frame_err
);

   typedef enum logic [1:0] {IDLE, SCLK_LO, SCLK_HI, DONE} state_t;

   localparam logic [7:0]  HALF_LAST = 8'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LAST  = 16'(SAMPLE_GAP - 1);

   state_t      state_q;
   logic [15:0] gap_q;
   logic [7:0]  half_q;
   logic [3:0]  bit_q;
   logic [15:0] shift_q;
   logic        cs_n_q;
   logic        sclk_q;
   logic [11:0] value_q;
   logic        chg_q;
   logic        err_q;
   logic        hdr_ok;

   assign hdr_ok = (shift_q[15:12] == 4'd0);

`ifdef ADC_AVG_EN
   logic [13:0] acc_q;
   logic [1:0]  cnt_q;
   logic [13:0] acc_sum;

   assign acc_sum = acc_q + {2'b00, shift_q[11:0]};

   function automatic logic [11:0] avg4(input logic [13:0] sum);
      return sum[13:2];
   endfunction
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gap_q   <= '0;
         half_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b1;
         value_q <= '0;
         chg_q   <= 1'b0;
         err_q   <= 1'b0;
`ifdef ADC_AVG_EN
         acc_q   <= '0;
         cnt_q   <= '0;
`endif
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (gap_q == GAP_LAST) begin
                  gap_q   <= '0;
                  cs_n_q  <= 1'b0;
                  sclk_q  <= 1'b0;
                  state_q <= SCLK_LO;
               end else begin
                  gap_q <= gap_q + 16'd1;
               end
            end
            SCLK_LO: begin
               if (half_q == HALF_LAST) begin
                  // The ADC output is stable here; capture it on the rising SCLK edge.
                  half_q  <= '0;
                  sclk_q  <= 1'b1;
                  shift_q <= {shift_q[14:0], adc_miso};
                  state_q <= SCLK_HI;
               end else begin
                  half_q <= half_q + 8'd1;
               end
            end
            SCLK_HI: begin
               if (half_q == HALF_LAST) begin
                  half_q <= '0;
                  if (bit_q == 4'd15) begin
                     bit_q   <= '0;
                     cs_n_q  <= 1'b1;
                     state_q <= DONE;
                     // Result is judged on the DONE entry edge so outputs move with DONE.
                     if (!hdr_ok) begin
                        err_q <= 1'b1;
                     end else begin
`ifdef ADC_AVG_EN
                        if (cnt_q == 2'd3) begin
                           value_q <= avg4(acc_sum);
                           chg_q   <= ~chg_q;
                           acc_q   <= '0;
                           cnt_q   <= '0;
                        end else begin
                           acc_q <= acc_sum;
                           cnt_q <= cnt_q + 2'd1;
                        end
`else
                        value_q <= shift_q[11:0];
                        chg_q   <= ~chg_q;
`endif
                     end
                  end else begin
                     bit_q   <= bit_q + 4'd1;
                     sclk_q  <= 1'b0;
                     state_q <= SCLK_LO;
                  end
               end else begin
                  half_q <= half_q + 8'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign adc_cs_n         = cs_n_q;
   assign adc_sclk         = sclk_q;
   assign adc_value        = value_q;
   assign adc_value_change = chg_q;
   assign frame_err        = err_q;

endmodule
